// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame buffer arbiter.
package fb_arb_pkg;

    typedef enum logic [0:0] {
        RD_PRIO   = 1'b0,
        WR_FORCED = 1'b1
    } arb_state_t;

    // Wide enough for MAX_WR_WAIT up to 15.
    localparam int WAIT_CNT_W = 4;
    localparam int STATS_W    = 16;

endpackage

// File: rtl/rd_return_pipe.sv
// Read-return pipeline: RD_LATENCY-deep shift register of read grants whose
// tail marks the cycle the register_file data is valid. Data is zeroed when
// not valid. Reset both flushes the pipe and masks the tail immediately, so a
// read in flight when reset arrives never produces a valid.
module rd_return_pipe
    import fb_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rd_grant_i,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic                  rd_data_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [RD_LATENCY-1:0] vld_q;

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            // Single-stage grant flag.
            always_ff @(posedge clk_i) begin
                if (reset_i) vld_q <= '0;
                else         vld_q <= rd_grant_i;
            end
        end else begin : g_latn
            // Multi-stage grant shift register.
            always_ff @(posedge clk_i) begin
                if (reset_i) vld_q <= '0;
                else         vld_q <= {vld_q[RD_LATENCY-2:0], rd_grant_i};
            end
        end
    endgenerate

    assign rd_data_valid_o = vld_q[RD_LATENCY-1] & ~reset_i;
    assign rd_data_o       = rd_data_valid_o ? mem_rd_data_i : '0;

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: shares one single-port register_file between the
// camera writer and the display reader. Reads have priority, but a write that
// keeps losing is forced through after MAX_WR_WAIT lost cycles.
// Optional statistics counters are built when ARB_STATS_EN is defined.
//
// state     | meaning
// RD_PRIO   | reads win contention; lost write cycles are counted
// WR_FORCED | pending write wins unconditionally for one cycle
module frame_buffer_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_WR_WAIT = 4,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  wr_valid_i,
    input  logic [ADDR_WIDTH-1:0] wr_address_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  rd_valid_i,
    input  logic [ADDR_WIDTH-1:0] rd_address_i,
    output logic                  rd_ready_o,
    output logic                  rd_data_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
`ifdef ARB_STATS_EN
    output logic [STATS_W-1:0]    stat_wr_stall_o,
    output logic [STATS_W-1:0]    stat_forced_o,
`endif
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = WAIT_CNT_W'(MAX_WR_WAIT);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WR_WAIT - 1);

    arb_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_shadow_q;
    logic                  wr_grant, rd_grant;
    logic                  forced_entry;

    // State, wait counter and idle-address shadow registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= RD_PRIO;
            wait_cnt_q    <= '0;
            addr_shadow_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (wr_grant)      addr_shadow_q <= wr_address_i;
            else if (rd_grant) addr_shadow_q <= rd_address_i;
        end
    end

    // Grant decision and next state; nothing is granted while in reset.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_grant   = 1'b0;
        rd_grant   = 1'b0;
        if (!reset_i) begin
            case (state_q)
                RD_PRIO: begin
                    if (rd_valid_i) begin
                        rd_grant = 1'b1;
                        if (wr_valid_i) begin
                            if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
                            if (wait_cnt_q == WAIT_LAST) state_d = WR_FORCED;
                        end else begin
                            wait_cnt_d = '0;
                        end
                    end else begin
                        wr_grant   = wr_valid_i;
                        wait_cnt_d = '0;
                    end
                end
                WR_FORCED: begin
                    // Either the write is accepted now or it was withdrawn;
                    // both end the forced window.
                    wr_grant   = wr_valid_i;
                    state_d    = RD_PRIO;
                    wait_cnt_d = '0;
                end
                default: begin
                    state_d    = RD_PRIO;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    assign forced_entry  = (state_q == RD_PRIO) && (state_d == WR_FORCED);
    assign wr_ready_o    = wr_grant;
    assign rd_ready_o    = rd_grant;
    assign mem_wr_en_o   = wr_grant;
    assign mem_wr_data_o = wr_grant ? wr_data_i : '0;
    assign mem_address_o = wr_grant ? wr_address_i :
                           rd_grant ? rd_address_i : addr_shadow_q;

    rd_return_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_return_pipe (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .rd_grant_i      (rd_grant),
        .mem_rd_data_i   (mem_rd_data_i),
        .rd_data_valid_o (rd_data_valid_o),
        .rd_data_o       (rd_data_o)
    );

`ifdef ARB_STATS_EN
    logic [STATS_W-1:0] stall_q, forced_q;

    // Saturating stall-cycle and forced-entry counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q  <= '0;
            forced_q <= '0;
        end else begin
            if (wr_valid_i && !wr_grant && stall_q != '1) stall_q <= stall_q + 1'b1;
            if (forced_entry && forced_q != '1)           forced_q <= forced_q + 1'b1;
        end
    end

    assign stat_wr_stall_o = stall_q;
    assign stat_forced_o   = forced_q;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: a cycle-by-cycle vector table plus hand
// sequences for streaming reads, RD_LATENCY=2 and reset during a read.
module tb_frame_buffer_arbiter;
    import fb_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid, rd_valid;
    logic [7:0] wr_address, wr_data, rd_address;

    logic       wr_ready1, rd_ready1, dv1, we1;
    logic [7:0] dout1, maddr1, mwd1, mrd1;
    logic       wr_ready2, rd_ready2, dv2, we2;
    logic [7:0] dout2, maddr2, mwd2, mrd2;
`ifdef ARB_STATS_EN
    logic [15:0] stall1, forced1, stall2, forced2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_buffer_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_WR_WAIT(4), .RD_LATENCY(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset),
        .wr_valid_i(wr_valid), .wr_address_i(wr_address), .wr_data_i(wr_data), .wr_ready_o(wr_ready1),
        .rd_valid_i(rd_valid), .rd_address_i(rd_address), .rd_ready_o(rd_ready1),
        .rd_data_valid_o(dv1), .rd_data_o(dout1),
        .mem_wr_en_o(we1), .mem_address_o(maddr1), .mem_wr_data_o(mwd1),
`ifdef ARB_STATS_EN
        .stat_wr_stall_o(stall1), .stat_forced_o(forced1),
`endif
        .mem_rd_data_i(mrd1)
    );

    frame_buffer_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_WR_WAIT(4), .RD_LATENCY(2)) u_dut2 (
        .clk_i(clk), .reset_i(reset),
        .wr_valid_i(wr_valid), .wr_address_i(wr_address), .wr_data_i(wr_data), .wr_ready_o(wr_ready2),
        .rd_valid_i(rd_valid), .rd_address_i(rd_address), .rd_ready_o(rd_ready2),
        .rd_data_valid_o(dv2), .rd_data_o(dout2),
        .mem_wr_en_o(we2), .mem_address_o(maddr2), .mem_wr_data_o(mwd2),
`ifdef ARB_STATS_EN
        .stat_wr_stall_o(stall2), .stat_forced_o(forced2),
`endif
        .mem_rd_data_i(mrd2)
    );

    // Register_file models: latency 1 for u_dut1, latency 2 for u_dut2.
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic [7:0] mrd2_s1;

    always @(posedge clk) begin
        if (we1) mem1[maddr1] <= mwd1;
        mrd1 <= mem1[maddr1];
        if (we2) mem2[maddr2] <= mwd2;
        mrd2_s1 <= mem2[maddr2];
        mrd2    <= mrd2_s1;
    end

    typedef struct {
        logic       rst, wv;
        logic [7:0] wa, wd;
        logic       rv;
        logic [7:0] ra;
        logic       e_wr, e_rd, e_we;
        logic [7:0] e_ma, e_mwd;
        logic       e_dv;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic rst, wv, input logic [7:0] wa, wd,
                                input logic rv, input logic [7:0] ra,
                                input logic e_wr, e_rd, e_we, input logic [7:0] e_ma, e_mwd,
                                input logic e_dv, input logic [7:0] e_dout);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra;
        v.e_wr = e_wr; v.e_rd = e_rd; v.e_we = e_we; v.e_ma = e_ma; v.e_mwd = e_mwd;
        v.e_dv = e_dv; v.e_dout = e_dout;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wv, input logic [7:0] wa, input logic [7:0] wd,
                         input logic rv, input logic [7:0] ra);
        @(negedge clk);
        reset = rst; wr_valid = wv; wr_address = wa; wr_data = wd;
        rd_valid = rv; rd_address = ra;
        #2;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b1; wr_address = 8'h33; wr_data = 8'h77;
        rd_valid = 1'b1; rd_address = 8'h44;

        //            rst wv  wa     wd     rv  ra     wr  rd  we  maddr  mwd    dv  dout
        vecs[0]  = mk(1, 1, 8'h33, 8'h77, 1, 8'h44,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        vecs[1]  = mk(1, 1, 8'h33, 8'h77, 1, 8'h44,  0, 0, 0, 8'h00, 8'h00, 0, 8'h00);
        vecs[2]  = mk(0, 1, 8'h30, 8'hE1, 0, 8'h00,  1, 0, 1, 8'h30, 8'hE1, 0, 8'h00);
        vecs[3]  = mk(0, 1, 8'h10, 8'h5A, 0, 8'h00,  1, 0, 1, 8'h10, 8'h5A, 0, 8'h00);
        vecs[4]  = mk(0, 0, 8'h00, 8'h00, 1, 8'h10,  0, 1, 0, 8'h10, 8'h00, 0, 8'h00);
        vecs[5]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00,  0, 0, 0, 8'h10, 8'h00, 1, 8'h5A);
        vecs[6]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00,  0, 0, 0, 8'h10, 8'h00, 0, 8'h00);
        vecs[7]  = mk(0, 1, 8'h20, 8'hC3, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 0, 8'h00);
        vecs[8]  = mk(0, 1, 8'h20, 8'hC3, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 1, 8'hE1);
        vecs[9]  = mk(0, 1, 8'h20, 8'hC3, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 1, 8'hE1);
        vecs[10] = mk(0, 1, 8'h20, 8'hC3, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 1, 8'hE1);
        vecs[11] = mk(0, 1, 8'h20, 8'hC3, 1, 8'h30,  1, 0, 1, 8'h20, 8'hC3, 1, 8'hE1);
        vecs[12] = mk(0, 0, 8'h00, 8'h00, 1, 8'h20,  0, 1, 0, 8'h20, 8'h00, 0, 8'h00);
        vecs[13] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00,  0, 0, 0, 8'h20, 8'h00, 1, 8'hC3);
        vecs[14] = mk(0, 1, 8'h40, 8'h11, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 0, 8'h00);
        vecs[15] = mk(0, 1, 8'h40, 8'h11, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 1, 8'hE1);
        vecs[16] = mk(0, 1, 8'h40, 8'h11, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 1, 8'hE1);
        vecs[17] = mk(0, 1, 8'h40, 8'h11, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 1, 8'hE1);
        vecs[18] = mk(0, 0, 8'h00, 8'h00, 1, 8'h30,  0, 0, 0, 8'h30, 8'h00, 1, 8'hE1);
        vecs[19] = mk(0, 0, 8'h00, 8'h00, 1, 8'h30,  0, 1, 0, 8'h30, 8'h00, 0, 8'h00);
        vecs[20] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00,  0, 0, 0, 8'h30, 8'h00, 1, 8'hE1);

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].rst, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra);
            chk("wr_ready",      i, 32'(wr_ready1), 32'(vecs[i].e_wr));
            chk("rd_ready",      i, 32'(rd_ready1), 32'(vecs[i].e_rd));
            chk("mem_wr_en",     i, 32'(we1),       32'(vecs[i].e_we));
            chk("mem_address",   i, 32'(maddr1),    32'(vecs[i].e_ma));
            chk("mem_wr_data",   i, 32'(mwd1),      32'(vecs[i].e_mwd));
            chk("rd_data_valid", i, 32'(dv1),       32'(vecs[i].e_dv));
            chk("rd_data",       i, 32'(dout1),     32'(vecs[i].e_dout));
        end

`ifdef ARB_STATS_EN
        chk("stat_wr_stall", 0, 32'(stall1),  32'd8);
        chk("stat_forced",   0, 32'(forced1), 32'd2);
`endif

        // Preload addresses 0..7 with i*3, then stream eight reads.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 8'(i), 8'(i * 3), 0, 8'h00);
            chk("preload_wr_ready", i, 32'(wr_ready1), 32'd1);
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 8'h00, 8'h00, (i < 8), 8'(i));
            chk("stream_rd_ready", i, 32'(rd_ready1), (i < 8) ? 32'd1 : 32'd0);
            if (i == 0 || i == 9) begin
                chk("stream_valid", i, 32'(dv1), 32'd0);
            end else begin
                chk("stream_valid", i, 32'(dv1),   32'd1);
                chk("stream_data",  i, 32'(dout1), 32'((i - 1) * 3));
            end
        end

        // Single read with RD_LATENCY=2: valid exactly two cycles after grant.
        drive(0, 0, 8'h00, 8'h00, 1, 8'h30);
        chk("lat2_rd_ready", 0, 32'(rd_ready2), 32'd1);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("lat2_valid",    1, 32'(dv2),   32'd0);
        chk("lat1_valid",    1, 32'(dv1),   32'd1);
        chk("lat1_data",     1, 32'(dout1), 32'hE1);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("lat2_valid",    2, 32'(dv2),   32'd1);
        chk("lat2_data",     2, 32'(dout2), 32'hE1);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("lat2_valid",    3, 32'(dv2),   32'd0);

        // Reset the cycle after a read grant: the read must never return.
        drive(0, 0, 8'h00, 8'h00, 1, 8'h30);
        chk("rstmid_rd_ready", 0, 32'(rd_ready1), 32'd1);
        drive(1, 0, 8'h00, 8'h00, 1, 8'h30);
        chk("rstmid_valid1", 1, 32'(dv1),       32'd0);
        chk("rstmid_valid2", 1, 32'(dv2),       32'd0);
        chk("rstmid_rd_rdy", 1, 32'(rd_ready1), 32'd0);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("rstmid_valid1", 2, 32'(dv1), 32'd0);
        chk("rstmid_valid2", 2, 32'(dv2), 32'd0);
        drive(0, 0, 8'h00, 8'h00, 0, 8'h00);
        chk("rstmid_valid2", 3, 32'(dv2),    32'd0);
        chk("rstmid_addr",   3, 32'(maddr1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
